// File: rtl/bcd_uart_pkg.sv
// bcd_uart_pkg
//   Shared types and constants for the BCD-to-ASCII UART transmitter.
//   - state_t     : byte serializer states (IDLE, START, DATA, STOP)
//   - ASCII_*     : characters emitted on the line
//   - baud_div()  : clocks per serial bit, rounded to nearest
//   - digit_char(): maps one BCD digit to its ASCII character ('?' if > 9)
package bcd_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ERR  = 8'h3F;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Rounded division so the bit period error stays within half a clock.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_ERR : (ASCII_ZERO + {4'h0, d});
    endfunction

endpackage

// File: rtl/bcd_uart_tx_byte.sv
// uart_tx_byte
//   8N1 byte serializer with a valid/ready handshake. Owns the baud
//   counter, the bit counter and the frame FSM. A byte offered while the
//   stop bit finishes is accepted on that same edge, so back-to-back bytes
//   leave no idle gap on the line.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   valid      : a byte is offered on data
//   data       : byte to send (sampled when valid && ready)
//   ready      : serializer can take a byte this cycle
//   fin        : last stop bit ends this cycle and nothing new follows
//   txd        : registered serial output, idle high
module uart_tx_byte
    import bcd_uart_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       fin,
    output logic       txd
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state, state_next;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          wrap;
    logic          accept;
    logic          txd_next;

    // End of the current serial bit.
    assign wrap = (baud_cnt == CW'(DIV - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (valid) state_next = START;
            START: if (wrap) state_next = DATA;
            DATA:  if (wrap && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (wrap) state_next = valid ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: handshake plus the value txd takes on the next edge.
    always_comb begin
        ready    = (state == IDLE) || (state == STOP && wrap);
        accept   = ready && valid;
        fin      = (state == STOP) && wrap && !valid;
        txd_next = txd;
        case (state)
            IDLE:  if (valid) txd_next = 1'b0;
            START: if (wrap) txd_next = shreg[0];
            // shreg[1] is the next bit because the shift happens on this edge
            DATA:  if (wrap) txd_next = (bit_cnt == 3'd7) ? 1'b1 : shreg[1];
            STOP:  if (wrap) txd_next = valid ? 1'b0 : 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

    // Datapath: counters, shift register and the txd flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            txd <= txd_next;
            if (accept) begin
                shreg    <= data;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE) begin
                baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
                if (state == DATA && wrap) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_uart_tx.sv
// bcd_uart_tx
//   Sends four BCD digits as an ASCII decimal string followed by CR LF
//   over an 8N1 serial line. Digits are latched on start; leading zeros
//   are optionally dropped (the ones digit is always sent).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : transmit request, honoured only while busy=0
//   thou, hund, ten, one  : BCD digits, most significant first
//   busy                  : string in progress
//   done                  : one-cycle pulse when the string completes
//   txd                   : serial output, idle high
module bcd_uart_tx
    import bcd_uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int SUPPRESS_LZ = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] thou,
    input  logic [3:0] hund,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    output logic       busy,
    output logic       done,
    output logic       txd
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);

    logic [5:0][7:0] full;      // all six characters, unsuppressed
    logic [5:0][7:0] list_in;   // compacted list built from live inputs
    logic [5:0][7:0] list_q;    // list latched at start
    logic [1:0]      fs;        // position of first digit to send
    logic [2:0]      n_in, n_q; // character count
    logic [2:0]      idx;       // character currently on the line
    logic [2:0]      nxt;
    logic            valid, ready, fin, accept;
    logic [7:0]      data;

    // Build the character list straight from the inputs so the first start
    // bit can go out on the same edge that latches the digits.
    always_comb begin
        full[0] = digit_char(thou);
        full[1] = digit_char(hund);
        full[2] = digit_char(ten);
        full[3] = digit_char(one);
        full[4] = ASCII_CR;
        full[5] = ASCII_LF;

        // A digit > 9 is nonzero here, so '?' is never suppressed.
        fs = 2'd0;
        if (SUPPRESS_LZ != 0) begin
            if      (thou != 4'd0) fs = 2'd0;
            else if (hund != 4'd0) fs = 2'd1;
            else if (ten  != 4'd0) fs = 2'd2;
            else                   fs = 2'd3;
        end

        for (int j = 0; j < 6; j++) begin
            list_in[3'(j)] = ASCII_LF;
            if (j + int'(fs) < 6) list_in[3'(j)] = full[3'(j + int'(fs))];
        end
        n_in = 3'd6 - {1'b0, fs};
    end

    // While idle the request itself is the handshake; while busy the next
    // latched character is offered whenever one remains.
    always_comb begin
        nxt = idx + 3'd1;
        if (!busy) begin
            valid = start;
            data  = list_in[0];
        end else begin
            valid = (nxt < n_q);
            data  = (nxt < 3'd6) ? list_q[nxt] : ASCII_LF;
        end
        accept = valid && ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            idx    <= '0;
            n_q    <= '0;
            list_q <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    list_q <= list_in;
                    n_q    <= n_in;
                    idx    <= '0;
                end
            end else begin
                if (accept) idx <= idx + 3'd1;
                if (fin) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    idx  <= '0;
                end
            end
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_byte (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .data  (data),
        .ready (ready),
        .fin   (fin),
        .txd   (txd)
    );

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Bench for bcd_uart_tx: two instances (leading-zero suppression on/off)
// share the same stimulus. A behavioural model predicts txd/busy/done per
// cycle; a line receiver decodes bytes for literal string checks.
module tb_bcd_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = 10;
    localparam int FRAME  = 10 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] thou = '0, hund = '0, ten = '0, one = '0;
    logic       busy1, done1, txd1;   // SUPPRESS_LZ=1 (model index 0)
    logic       busy0, done0, txd0;   // SUPPRESS_LZ=0 (model index 1)

    bcd_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SUPPRESS_LZ(1)) dut_lz (
        .clk(clk), .reset(reset), .start(start),
        .thou(thou), .hund(hund), .ten(ten), .one(one),
        .busy(busy1), .done(done1), .txd(txd1)
    );

    bcd_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SUPPRESS_LZ(0)) dut_nz (
        .clk(clk), .reset(reset), .start(start),
        .thou(thou), .hund(hund), .ten(ten), .one(one),
        .busy(busy0), .done(done0), .txd(txd0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input int m, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", nm, m, cyc, act, want);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              m_act [2];
    int              m_k   [2];
    int              m_n   [2];
    logic [5:0][7:0] m_str [2];

    function automatic int build(input logic [15:0] dg, input bit lz,
                                 output logic [5:0][7:0] s);
        logic [7:0] q[$];
        logic [3:0] d;
        bit seen;
        seen = !lz;
        for (int i = 0; i < 4; i++) begin
            d = dg[15 - 4*i -: 4];
            if (d != 4'd0 || i == 3) seen = 1'b1;
            if (seen) q.push_back((d > 4'd9) ? 8'h3F : 8'h30 + {4'h0, d});
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        s = '0;
        for (int i = 0; i < q.size(); i++) s[i] = q[i];
        return q.size();
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (reset) m_act[m] = 1'b0;
            else if (start && !(m_act[m] && (cyc - 1 - m_k[m]) < m_n[m] * FRAME)) begin
                m_act[m] = 1'b1;
                m_k[m]   = cyc;
                m_n[m]   = build({thou, hund, ten, one}, (m == 0), m_str[m]);
            end
        end
    end

    function automatic void predict(input int m, output logic t, output logic b, output logic d);
        int el, ch, r;
        t = 1'b1; b = 1'b0; d = 1'b0;
        if (m_act[m] && !reset) begin
            el = cyc - m_k[m];
            if (el < m_n[m] * FRAME) begin
                b  = 1'b1;
                ch = el / FRAME;
                r  = (el % FRAME) / DIV;
                if (r == 0)      t = 1'b0;
                else if (r == 9) t = 1'b1;
                else             t = m_str[m][ch][r-1];
            end else if (el == m_n[m] * FRAME) begin
                d = 1'b1;
            end
        end
    endfunction

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        logic et, eb, ed;
        for (int m = 0; m < 2; m++) begin
            predict(m, et, eb, ed);
            chk("txd",  m, (m == 0) ? txd1  : txd0,  et);
            chk("busy", m, (m == 0) ? busy1 : busy0, eb);
            chk("done", m, (m == 0) ? done1 : done0, ed);
        end
    end

    // ---------------- line receiver and monitors ----------------
    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];
    bit         rx_on [2];
    int         rx_cnt[2];
    logic [7:0] rx_sh [2];
    int         bcnt[2], done_at[2], last_rise[2], rise_gap[2];
    logic       pb[2];

    always @(negedge clk) begin
        logic tx, bz, dn;
        for (int m = 0; m < 2; m++) begin
            tx = (m == 0) ? txd1  : txd0;
            bz = (m == 0) ? busy1 : busy0;
            dn = (m == 0) ? done1 : done0;
            if (reset) begin
                rx_on[m] = 1'b0;
            end else if (!rx_on[m]) begin
                if (tx == 1'b0) begin
                    rx_on[m]  = 1'b1;
                    rx_cnt[m] = 0;
                end
            end else begin
                rx_cnt[m]++;
                if (rx_cnt[m] >= 15 && rx_cnt[m] <= 85 && (rx_cnt[m] - 15) % 10 == 0)
                    rx_sh[m][(rx_cnt[m] - 15) / 10] = tx;
                if (rx_cnt[m] == 95) begin
                    rx_on[m] = 1'b0;
                    if (m == 0) rxq0.push_back(rx_sh[m]);
                    else        rxq1.push_back(rx_sh[m]);
                end
            end
            if (bz) bcnt[m]++;
            if (bz && !pb[m]) begin
                rise_gap[m]  = cyc - last_rise[m];
                last_rise[m] = cyc;
            end
            pb[m] = bz;
            if (dn) done_at[m] = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mon();
        rxq0.delete();
        rxq1.delete();
        bcnt[0] = 0;
        bcnt[1] = 0;
    endtask

    task automatic send(input logic [15:0] dg, output int k);
        @(negedge clk);
        {thou, hund, ten, one} = dg;
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int lim;
        lim = 0;
        @(negedge clk);
        while ((busy1 || busy0) && lim < 2000) begin
            @(negedge clk);
            lim++;
        end
        total++;
        if (lim >= 2000) begin
            bad++;
            $display("FAIL idle_timeout cyc=%0d busy=%b%b want=00", cyc, busy1, busy0);
        end
    endtask

    // want holds the expected characters left-justified, first char in MSBs.
    task automatic chk_rx(input string nm, input int m, input logic [47:0] want, input int n);
        logic [7:0] got[$];
        logic [7:0] w;
        got = (m == 0) ? rxq0 : rxq1;
        total++;
        if (got.size() != n) begin
            bad++;
            $display("FAIL %s_len dut%0d got=%0d want=%0d", nm, m, got.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = want[47 - 8*i -: 8];
                total++;
                if (got[i] !== w) begin
                    bad++;
                    $display("FAIL %s_byte%0d dut%0d got=%h want=%h", nm, i, m, got[i], w);
                end
            end
        end
    endtask

    task automatic scen(input string nm, input logic [15:0] dg,
                        input logic [47:0] e1, input int n1,
                        input logic [47:0] e0, input int n0);
        int k;
        clear_mon();
        send(dg, k);
        wait_idle();
        repeat (3) @(negedge clk);
        chk_rx(nm, 0, e1, n1);
        chk_rx(nm, 1, e0, n0);
        chk_int({nm, "_busy_lz"}, bcnt[0], n1 * FRAME);
        chk_int({nm, "_busy_nz"}, bcnt[1], n0 * FRAME);
        chk_int({nm, "_done_lz"}, done_at[0] - k, n1 * FRAME);
        chk_int({nm, "_done_nz"}, done_at[1] - k, n0 * FRAME);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k, lim;
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 0; m_k[m] = 0; m_n[m] = 0; m_str[m] = '0;
            rx_on[m] = 0; rx_cnt[m] = 0; rx_sh[m] = '0;
            bcnt[m] = 0; done_at[m] = 0; last_rise[m] = 0; rise_gap[m] = 0; pb[m] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_txd",  0, txd1,  1'b1);
        chk("rst_busy", 0, busy1, 1'b0);
        chk("rst_done", 0, done1, 1'b0);
        chk("rst_txd",  1, txd0,  1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        scen("d1234", 16'h1234, {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, 6,
                                {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, 6);
        scen("d0007", 16'h0007, {8'h37, 8'h0D, 8'h0A, 24'h0}, 3,
                                {8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A}, 6);
        scen("d0000", 16'h0000, {8'h30, 8'h0D, 8'h0A, 24'h0}, 3,
                                {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}, 6);
        scen("d0500", 16'h0500, {8'h35, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h0}, 5,
                                {8'h30, 8'h35, 8'h30, 8'h30, 8'h0D, 8'h0A}, 6);
        scen("d00A3", 16'h00A3, {8'h3F, 8'h33, 8'h0D, 8'h0A, 16'h0}, 4,
                                {8'h30, 8'h30, 8'h3F, 8'h33, 8'h0D, 8'h0A}, 6);

        // start during busy with new digits: must be ignored
        clear_mon();
        send(16'h1234, k);
        lim = 0;
        while (cyc < k + 49 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        {thou, hund, ten, one} = 16'h9999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk_rx("ignore", 0, {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, 6);
        chk_rx("ignore", 1, {8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, 6);
        chk_int("ignore_busy", bcnt[0], 600);

        // start held high: restart on the first idle cycle
        @(negedge clk);
        {thou, hund, ten, one} = 16'h0007;
        start = 1'b1;
        k = cyc + 1;
        lim = 0;
        while (cyc < k + 606 && lim < 1000) begin
            @(negedge clk);
            lim++;
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk_int("held_gap_lz", rise_gap[0], 301);
        chk_int("held_gap_nz", rise_gap[1], 601);

        // reset in the middle of a frame
        clear_mon();
        send(16'h1234, k);
        repeat (37) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_txd",  0, txd1,  1'b1);
        chk("midrst_busy", 0, busy1, 1'b0);
        chk("midrst_done", 0, done1, 1'b0);
        chk("midrst_txd",  1, txd0,  1'b1);
        chk("midrst_busy", 1, busy0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_txd",  0, txd1,  1'b1);
        chk("post_rst_busy", 0, busy1, 1'b0);
        chk("post_rst_txd",  1, txd0,  1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
